// File: rtl/fb_swap_scheduler.sv
// Double-buffered framebuffer write scheduler: clears the back buffer,
// forwards rasterizer pixel writes, and swaps buffers on VGA vsync falls.
module fb_swap_scheduler #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned NUM_PIXELS  = 76800,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  frame_done,
  input  logic                  pix_valid,
  input  logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [7:0]            pix_data,
  output logic                  pix_ready,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [7:0]            dina,
  output logic                  front,
  output logic                  frame_start,
  output logic [7:0]            late_frames
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    CLEAR,
    RENDER,
    WAIT_SWAP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_prev;
  logic                  w_vs_fall;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  w_clr_last;
  logic                  r_front;
  logic                  r_frame_start;
  logic [7:0]            r_late;

  assign w_vs_fall   = r_prev & ~r_s2;
  assign w_clr_last  = (r_clr_cnt == LP_LAST);
  assign front       = r_front;
  assign frame_start = r_frame_start;
  assign late_frames = r_late;

  // Two-flop vsync synchroniser plus edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= vsync;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_next;
  end

  // Next-state logic; frame_done only matters in RENDER, vs_fall only in WAIT_SWAP
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR:     if (w_clr_last) w_next = RENDER;
      RENDER:    if (frame_done) w_next = WAIT_SWAP;
      WAIT_SWAP: if (w_vs_fall)  w_next = CLEAR;
      default:   w_next = CLEAR;
    endcase
  end

  // Clear counter, buffer select, frame-start pulse and missed-swap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt     <= '0;
      r_front       <= 1'b0;
      r_frame_start <= 1'b0;
      r_late        <= '0;
    end else begin
      r_frame_start <= (r_state == CLEAR) && w_clr_last;
      if (r_state == CLEAR && !w_clr_last) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                                 r_clr_cnt <= '0;
      if (w_vs_fall) begin
        if (r_state == WAIT_SWAP)  r_front <= ~r_front;
        else if (r_late != 8'hFF)  r_late  <= r_late + 8'd1;
      end
    end
  end

  // Framebuffer write port mux; pixel path is combinational for zero latency
  always_comb begin
    pix_ready = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    unique case (r_state)
      CLEAR: begin
        wea   = ~rst;
        addra = r_clr_cnt;
        dina  = CLEAR_COLOR;
      end
      RENDER: begin
        pix_ready = 1'b1;
        wea       = pix_valid && (pix_addr <= LP_LAST) && !rst;
        addra     = pix_addr;
        dina      = pix_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Scoreboard bench for fb_swap_scheduler with NUM_PIXELS=16.
module tb_fb_swap_scheduler;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       frame_done = 1'b0;
  logic       pix_valid = 1'b0;
  logic [4:0] pix_addr = '0;
  logic [7:0] pix_data = '0;
  logic       pix_ready;
  logic       wea;
  logic [4:0] addra;
  logic [7:0] dina;
  logic       front;
  logic       frame_start;
  logic [7:0] late_frames;

  int unsigned errors = 0;
  int unsigned checks = 0;
  wr_t         exp_q[$];

  fb_swap_scheduler #(
    .ADDR_WIDTH (5),
    .NUM_PIXELS (16),
    .CLEAR_COLOR(8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_done (frame_done),
    .pix_valid  (pix_valid),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .front      (front),
    .frame_start(frame_start),
    .late_frames(late_frames)
  );

  always #5 clk = ~clk;

  // Monitor: every framebuffer write must match the head of the expected queue
  always @(negedge clk) begin
    if (wea) begin
      wr_t e;
      checks++;
      if (rst) begin
        errors++;
        $display("FAIL wea_in_reset: wea=1 addra=%0d while rst high, required wea=0", addra);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addra=%0d dina=%02h, required no write", addra, dina);
      end else begin
        e = exp_q.pop_front();
        if (addra !== e.addr || dina !== e.data) begin
          errors++;
          $display("FAIL write: addra=%0d dina=%02h, required addra=%0d dina=%02h",
                   addra, dina, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push_wr(5'(i), 8'h00);
  endtask

  // Bounded wait for frame_start, then confirm RENDER entry and a complete clear
  task automatic wait_fs(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_frame_start"}, 32'(seen), 1);
    chk({name, "_pix_ready"}, 32'(pix_ready), 1);
    @(negedge clk);
    chk({name, "_fs_one_cycle"}, 32'(frame_start), 0);
    chk({name, "_clear_done"}, exp_q.size(), 0);
  endtask

  task automatic vs_pulse;
    vsync = 1'b0;
    repeat (4) tick();
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic seen;
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_front", 32'(front), 0);
    chk("rst_late", 32'(late_frames), 0);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    push_clear(16);
    tick();
    rst = 1'b0;
    wait_fs("init");

    // Pixel writes, including the address boundary
    tick(); pix_valid = 1'b1; pix_addr = 5'd5;  pix_data = 8'hA7; push_wr(5'd5, 8'hA7);
    @(negedge clk); chk("px5_wea", 32'(wea), 1);
    tick(); pix_addr = 5'd20; pix_data = 8'h3C;
    @(negedge clk); chk("px20_wea", 32'(wea), 0); chk("px20_ready", 32'(pix_ready), 1);
    tick(); pix_addr = 5'd15; pix_data = 8'h0F; push_wr(5'd15, 8'h0F);
    @(negedge clk);
    tick(); pix_addr = 5'd16; pix_data = 8'h99;
    @(negedge clk); chk("px16_wea", 32'(wea), 0);
    tick(); pix_valid = 1'b0;

    // Two missed swaps while rendering
    vs_pulse();
    vs_pulse();
    chk("late2_front", 32'(front), 0);
    chk("late2_count", 32'(late_frames), 2);
    chk("late2_render", 32'(pix_ready), 1);

    // Pixel written in the frame_done cycle, then WAIT_SWAP outputs
    pix_valid = 1'b1; pix_addr = 5'd3; pix_data = 8'h55; frame_done = 1'b1; push_wr(5'd3, 8'h55);
    tick(); frame_done = 1'b0; pix_addr = 5'd7; pix_data = 8'h66;
    @(negedge clk);
    chk("wait_pix_ready", 32'(pix_ready), 0);
    chk("wait_wea", 32'(wea), 0);
    chk("wait_addra", 32'(addra), 0);
    chk("wait_dina", 32'(dina), 0);
    tick(); pix_valid = 1'b0; frame_done = 1'b1;
    tick(); frame_done = 1'b0; push_clear(16); vsync = 1'b0;
    tick();
    tick(); chk("swap_front_e2", 32'(front), 0);
    tick(); chk("swap_front_e3", 32'(front), 1);
    frame_done = 1'b1;
    tick(); frame_done = 1'b0; vsync = 1'b1;
    wait_fs("swap1");
    chk("swap1_late", 32'(late_frames), 2);

    // Reset in the middle of a clear
    tick(); frame_done = 1'b1;
    tick(); frame_done = 1'b0; push_clear(9); vsync = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wea) begin
        seen = 1'b1;
        break;
      end
    end
    chk("swap2_clear_start", 32'(seen), 1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midclr_rst_wea", 32'(wea), 0);
    chk("midclr_rst_late", 32'(late_frames), 0);
    chk("midclr_rst_front", 32'(front), 0);
    vsync = 1'b1;
    tick(); tick();
    push_clear(16);
    rst = 1'b0;
    wait_fs("rst_clear");
    chk("rst_clear_front", 32'(front), 0);

    // frame_done coinciding with a vsync fall
    tick(); vsync = 1'b0;
    tick();
    tick(); frame_done = 1'b1;
    tick(); frame_done = 1'b0;
    chk("coinc_late", 32'(late_frames), 1);
    chk("coinc_front", 32'(front), 0);
    chk("coinc_wait", 32'(pix_ready), 0);
    vsync = 1'b1;
    repeat (4) tick();
    chk("coinc_front_hold", 32'(front), 0);
    push_clear(16);
    vsync = 1'b0;
    wait_fs("coinc_swap");
    chk("coinc_swap_front", 32'(front), 1);
    chk("coinc_swap_late", 32'(late_frames), 1);
    vsync = 1'b1;
    repeat (4) tick();

    // Saturation of the missed-swap counter
    for (int i = 0; i < 300; i++) vs_pulse();
    chk("sat_late", 32'(late_frames), 255);
    chk("sat_front", 32'(front), 1);
    chk("sat_render", 32'(pix_ready), 1);

    repeat (2) tick();
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
